// File: rtl/key_debounce.sv
// Rhythm-pad button debouncer: turns the 500 Hz divider output into a sample strobe
// and runs one four-state debounce FSM per key, emitting a clean level plus press/release pulses.
module key_debounce #(
    parameter int N_KEYS     = 4,
    parameter int STABLE_CNT = 4,
    parameter int CNT_W      = 4
) (
    input  logic                  CLK_50M,
    input  logic                  RST,
    input  logic                  TICK_IN,
    input  logic [N_KEYS-1:0]     KEY_IN,
    output logic                  SAMPLE_STB,
    output logic [N_KEYS-1:0]     KEY_LEVEL,
    output logic [N_KEYS-1:0]     KEY_PRESS,
    output logic [N_KEYS-1:0]     KEY_RELEASE,
    output logic [2*N_KEYS-1:0]   STATE_DBG
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } key_state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic              t1, t2, t3;
    logic [N_KEYS-1:0] ks_meta, ks;

    key_state_t        state_q [N_KEYS];
    key_state_t        state_d [N_KEYS];
    logic [CNT_W-1:0]  cnt_q   [N_KEYS];
    logic [CNT_W-1:0]  cnt_d   [N_KEYS];
    logic [N_KEYS-1:0] level_d, press_d, release_d;

    // TICK_IN is only ever data here: synchronise it, then strobe on its rising edge.
    always_ff @(posedge CLK_50M) begin
        if (RST) begin
            t1         <= 1'b0;
            t2         <= 1'b0;
            t3         <= 1'b0;
            SAMPLE_STB <= 1'b0;
            ks_meta    <= '0;
            ks         <= '0;
        end else begin
            t1         <= TICK_IN;
            t2         <= t1;
            t3         <= t2;
            SAMPLE_STB <= t2 & ~t3;
            ks_meta    <= KEY_IN;
            ks         <= ks_meta;
        end
    end

    always_comb begin
        level_d   = KEY_LEVEL;
        press_d   = '0;
        release_d = '0;
        for (int k = 0; k < N_KEYS; k++) begin
            state_d[k] = state_q[k];
            cnt_d[k]   = cnt_q[k];
            if (SAMPLE_STB) begin
                unique case (state_q[k])
                    IDLE: begin
                        if (ks[k]) begin
                            state_d[k] = PRESS_WAIT;
                            cnt_d[k]   = CNT_ONE;
                        end
                    end
                    PRESS_WAIT: begin
                        if (!ks[k]) begin
                            state_d[k] = IDLE;
                            cnt_d[k]   = '0;
                        end else if (cnt_q[k] == CNT_LAST) begin
                            state_d[k] = PRESSED;
                            cnt_d[k]   = '0;
                            level_d[k] = 1'b1;
                            press_d[k] = 1'b1;
                        end else begin
                            cnt_d[k] = cnt_q[k] + CNT_ONE;
                        end
                    end
                    PRESSED: begin
                        if (!ks[k]) begin
                            state_d[k] = RELEASE_WAIT;
                            cnt_d[k]   = CNT_ONE;
                        end
                    end
                    RELEASE_WAIT: begin
                        // A single high sample snaps back to PRESSED; the release count restarts.
                        if (ks[k]) begin
                            state_d[k] = PRESSED;
                            cnt_d[k]   = '0;
                        end else if (cnt_q[k] == CNT_LAST) begin
                            state_d[k]   = IDLE;
                            cnt_d[k]     = '0;
                            level_d[k]   = 1'b0;
                            release_d[k] = 1'b1;
                        end else begin
                            cnt_d[k] = cnt_q[k] + CNT_ONE;
                        end
                    end
                    default: begin
                        state_d[k] = IDLE;
                        cnt_d[k]   = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge CLK_50M) begin
        if (RST) begin
            for (int k = 0; k < N_KEYS; k++) begin
                state_q[k] <= IDLE;
                cnt_q[k]   <= '0;
            end
            KEY_LEVEL   <= '0;
            KEY_PRESS   <= '0;
            KEY_RELEASE <= '0;
        end else begin
            for (int k = 0; k < N_KEYS; k++) begin
                state_q[k] <= state_d[k];
                cnt_q[k]   <= cnt_d[k];
            end
            KEY_LEVEL   <= level_d;
            KEY_PRESS   <= press_d;
            KEY_RELEASE <= release_d;
        end
    end

    always_comb begin
        STATE_DBG = '0;
        for (int k = 0; k < N_KEYS; k++) begin
            STATE_DBG[2*k +: 2] = state_q[k];
        end
    end

endmodule

// File: tb/tb_key_debounce.sv
// Randomised bench for key_debounce: a run-length debounce model predicts strobe,
// level and pulse outputs every cycle; pulse events also go through an expected queue.
module tb_key_debounce;

    localparam int N_KEYS     = 4;
    localparam int STABLE_CNT = 4;
    localparam int CNT_W      = 4;

    logic                CLK_50M = 1'b0;
    logic                RST     = 1'b1;
    logic                TICK_IN = 1'b0;
    logic [N_KEYS-1:0]   KEY_IN  = '0;
    logic                SAMPLE_STB;
    logic [N_KEYS-1:0]   KEY_LEVEL, KEY_PRESS, KEY_RELEASE;
    logic [2*N_KEYS-1:0] STATE_DBG;

    key_debounce #(
        .N_KEYS     (N_KEYS),
        .STABLE_CNT (STABLE_CNT),
        .CNT_W      (CNT_W)
    ) dut (
        .CLK_50M     (CLK_50M),
        .RST         (RST),
        .TICK_IN     (TICK_IN),
        .KEY_IN      (KEY_IN),
        .SAMPLE_STB  (SAMPLE_STB),
        .KEY_LEVEL   (KEY_LEVEL),
        .KEY_PRESS   (KEY_PRESS),
        .KEY_RELEASE (KEY_RELEASE),
        .STATE_DBG   (STATE_DBG)
    );

    // ---------------- clock / reset ----------------
    always #10 CLK_50M = ~CLK_50M;

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;
    logic [2*N_KEYS-1:0] exp_q[$];
    int m_press_cnt   = 0;
    int dut_press_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // tick_seen[i] = TICK_IN as seen i+1 edges ago; key_seen likewise for KEY_IN.
    logic              tick_seen [3];
    logic [N_KEYS-1:0] key_seen  [2];
    logic              m_stb   = 1'b0;
    logic [N_KEYS-1:0] m_lvl   = '0;
    logic [N_KEYS-1:0] m_press = '0;
    logic [N_KEYS-1:0] m_rel   = '0;
    int                run [N_KEYS];

    initial begin
        for (int i = 0; i < 3; i++) tick_seen[i] = 1'b0;
        key_seen[0] = '0;
        key_seen[1] = '0;
        for (int k = 0; k < N_KEYS; k++) run[k] = 0;
    end

    always @(posedge CLK_50M) begin
        if (RST) begin
            for (int i = 0; i < 3; i++) tick_seen[i] = 1'b0;
            key_seen[0] = '0;
            key_seen[1] = '0;
            m_stb   = 1'b0;
            m_lvl   = '0;
            m_press = '0;
            m_rel   = '0;
            for (int k = 0; k < N_KEYS; k++) run[k] = 0;
        end else begin
            m_press = '0;
            m_rel   = '0;
            if (m_stb) begin
                // A key flips once STABLE_CNT consecutive samples disagree with its level.
                for (int k = 0; k < N_KEYS; k++) begin
                    if (key_seen[1][k] != m_lvl[k]) begin
                        run[k]++;
                        if (run[k] == STABLE_CNT) begin
                            m_lvl[k] = ~m_lvl[k];
                            if (m_lvl[k]) m_press[k] = 1'b1;
                            else          m_rel[k]   = 1'b1;
                            run[k] = 0;
                        end
                    end else begin
                        run[k] = 0;
                    end
                end
            end
            m_stb        = tick_seen[1] & ~tick_seen[2];
            tick_seen[2] = tick_seen[1];
            tick_seen[1] = tick_seen[0];
            tick_seen[0] = TICK_IN;
            key_seen[1]  = key_seen[0];
            key_seen[0]  = KEY_IN;
            if ((m_press | m_rel) != '0) exp_q.push_back({m_press, m_rel});
            m_press_cnt += $countones(m_press);
        end
    end

    // ---------------- driver ----------------
    int tick_cnt  = 4;
    int tick_half = 4;
    bit tick_run  = 1'b1;
    bit tick_rand = 1'b1;
    int key_timer [N_KEYS];

    initial for (int k = 0; k < N_KEYS; k++) key_timer[k] = 1;

    task automatic compare_outputs();
        check("sample_stb", 32'(SAMPLE_STB), 32'(m_stb));
        check("key_level", 32'(KEY_LEVEL), 32'(m_lvl));
        check("key_press", 32'(KEY_PRESS), 32'(m_press));
        check("key_release", 32'(KEY_RELEASE), 32'(m_rel));
        check("press_and_release", 32'(KEY_PRESS & KEY_RELEASE), 32'd0);
        dut_press_cnt += $countones(KEY_PRESS);
        if ((KEY_PRESS | KEY_RELEASE) != '0) begin
            if (exp_q.size() == 0) check("unexpected_pulse", 32'({KEY_PRESS, KEY_RELEASE}), 32'd0);
            else check("pulse_event", 32'({KEY_PRESS, KEY_RELEASE}), 32'(exp_q.pop_front()));
        end
    endtask

    // One cycle: compare at negedge, then set up inputs for the next rising edge.
    task automatic step(input int hold_min, input int hold_max, input bit drive_keys);
        @(negedge CLK_50M);
        compare_outputs();
        if (tick_run) begin
            tick_cnt--;
            if (tick_cnt <= 0) begin
                TICK_IN = ~TICK_IN;
                tick_cnt = tick_rand ? int'($urandom_range(3, 8)) : tick_half;
            end
        end
        if (drive_keys) begin
            for (int k = 0; k < N_KEYS; k++) begin
                key_timer[k]--;
                if (key_timer[k] <= 0) begin
                    KEY_IN[k]    = 1'($urandom_range(0, 1));
                    key_timer[k] = int'($urandom_range(hold_min, hold_max));
                end
            end
        end
    endtask

    initial begin
        RST = 1'b1;
        repeat (3) step(1, 1, 1'b0);
        RST = 1'b0;

        // Long stable holds: presses and releases get accepted.
        repeat (4000) step(20, 200, 1'b1);

        // Chattering keys: most changes must be rejected.
        repeat (3000) step(1, 15, 1'b1);

        // All keys change together on a regular tick.
        tick_rand = 1'b0;
        for (int r = 0; r < 5; r++) begin
            KEY_IN = '1;
            repeat (100) step(1, 1, 1'b0);
            KEY_IN = '0;
            repeat (100) step(1, 1, 1'b0);
        end
        tick_rand = 1'b1;

        // Resets landing in the middle of debounce activity.
        for (int c = 0; c < 3000; c++) begin
            RST = ($urandom_range(0, 299) == 0);
            step(20, 200, 1'b1);
        end
        RST = 1'b0;

        // Key 2 held through a reset must be re-accepted from scratch.
        KEY_IN = 4'b0100;
        repeat (150) step(1, 1, 1'b0);
        RST = 1'b1;
        step(1, 1, 1'b0);
        RST = 1'b0;
        repeat (150) step(1, 1, 1'b0);

        // Tick stalled while keys chatter: nothing may change.
        tick_run = 1'b0;
        repeat (1000) step(5, 60, 1'b1);
        tick_run = 1'b1;
        repeat (600) step(20, 200, 1'b1);

        check("press_total", 32'(dut_press_cnt), 32'(m_press_cnt));
        check("events_left", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
